// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared defaults for the multi-port MIPS register file and the address of
// the hard-wired zero register.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NREAD_DEF  = 2;

  // Register that reads as zero when ZERO_R0 is enabled
  localparam int R0_ADDR = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// One pending bit per register plus a registered count of pending bits.
// Used by decode for hazard detection.
//
// Ports:
//   clk_i, rst_ni           clock, async active-low reset
//   clr0_en_i, clr0_addr_i  write port 0 (ALU) retires its destination
//   clr1_en_i, clr1_addr_i  write port 1 (load) retires its destination
//   set_en_i, set_addr_i    issue marks a destination pending
//   pend_o                  registered pending bits, one per register
//   pend_cnt_o              registered number of pending bits
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int ZERO_R0 = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clr0_en_i,
  input  logic [ADDR_W-1:0]      clr0_addr_i,
  input  logic                   clr1_en_i,
  input  logic [ADDR_W-1:0]      clr1_addr_i,
  input  logic                   set_en_i,
  input  logic [ADDR_W-1:0]      set_addr_i,
  output logic [(2**ADDR_W)-1:0] pend_o,
  output logic [ADDR_W:0]        pend_cnt_o
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] pend_q, pend_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;
  logic [ADDR_W:0]  n_rise, n_fall;
  logic             set_ok;

  assign set_ok = set_en_i &&
                  !((ZERO_R0 != 0) && (set_addr_i == ADDR_W'(R0_ADDR)));

  always_comb begin
    pend_d = pend_q;
    if (clr0_en_i) pend_d[clr0_addr_i] = 1'b0;
    if (clr1_en_i) pend_d[clr1_addr_i] = 1'b0;
    // Applied after the clears: a newly issued producer outranks a retiring one
    if (set_ok)    pend_d[set_addr_i]  = 1'b1;

    // Count real transitions only, so redundant sets/clears leave the count alone
    n_rise = '0;
    n_fall = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (pend_d[i] && !pend_q[i]) n_rise = n_rise + (ADDR_W+1)'(1);
      if (!pend_d[i] && pend_q[i]) n_fall = n_fall + (ADDR_W+1)'(1);
    end
    cnt_d = cnt_q + n_rise - n_fall;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_o     = pend_q;
  assign pend_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
// Multi-port register file: NREAD combinational read ports, two write ports
// (0 = ALU, 1 = load; port 1 wins on an address collision), optional
// same-cycle write-to-read bypass, and a pending scoreboard.
//
// Ports:
//   clk_i, rst_ni         clock, async active-low reset
//   ra_i                  packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_o                  packed read data, port k at [k*DATA_W +: DATA_W]
//   rbusy_o               pending bit of each addressed register
//   wa0_i/wen0_i/wd0_i    write port 0
//   wa1_i/wen1_i/wd1_i    write port 1
//   set_en_i, set_addr_i  mark destination pending on issue
//   pend_cnt_o            number of pending registers
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NREAD   = NREAD_DEF,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NREAD*ADDR_W-1:0] ra_i,
  output logic [NREAD*DATA_W-1:0] rd_o,
  output logic [NREAD-1:0]        rbusy_o,
  input  logic [ADDR_W-1:0]       wa0_i,
  input  logic                    wen0_i,
  input  logic [DATA_W-1:0]       wd0_i,
  input  logic [ADDR_W-1:0]       wa1_i,
  input  logic                    wen1_i,
  input  logic [DATA_W-1:0]       wd1_i,
  input  logic                    set_en_i,
  input  logic [ADDR_W-1:0]       set_addr_i,
  output logic [ADDR_W:0]         pend_cnt_o
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic              we0_ok, we1_ok;

  assign we0_ok = wen0_i && !((ZERO_R0 != 0) && (wa0_i == ADDR_W'(R0_ADDR)));
  assign we1_ok = wen1_i && !((ZERO_R0 != 0) && (wa1_i == ADDR_W'(R0_ADDR)));

  always_comb begin
    mem_d = mem_q;
    if (we0_ok) mem_d[wa0_i] = wd0_i;
    if (we1_ok) mem_d[wa1_i] = wd1_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Clearing bit 0 is harmless when ZERO_R0 is set: it can never be pending
  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_R0 (ZERO_R0)
  ) u_scoreboard (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clr0_en_i   (wen0_i),
    .clr0_addr_i (wa0_i),
    .clr1_en_i   (wen1_i),
    .clr1_addr_i (wa1_i),
    .set_en_i    (set_en_i),
    .set_addr_i  (set_addr_i),
    .pend_o      (pend),
    .pend_cnt_o  (pend_cnt_o)
  );

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra_k;
    logic [DATA_W-1:0] rd_k;
    logic              hit0, hit1;

    assign ra_k = ra_i[k*ADDR_W +: ADDR_W];
    assign hit0 = (BYPASS != 0) && wen0_i && (wa0_i == ra_k);
    assign hit1 = (BYPASS != 0) && wen1_i && (wa1_i == ra_k);

    always_comb begin
      if ((ZERO_R0 != 0) && (ra_k == ADDR_W'(R0_ADDR))) rd_k = '0;
      else if (hit1)                                    rd_k = wd1_i;
      else if (hit0)                                    rd_k = wd0_i;
      else                                              rd_k = mem_q[ra_k];
    end

    assign rd_o[k*DATA_W +: DATA_W] = rd_k;
    // A bypassed write already delivers valid data, so the register is not busy
    assign rbusy_o[k] = pend[ra_k] & ~(hit0 | hit1);
  end

endmodule
